// File: rtl/rps_pkg.sv
// Shared constants for the stone/paper/scissors match engine: move, result and winner codes,
// FSM states, and the build-dependent number of legal moves (RPS_LIZARD_SPOCK_EN).
package rps_pkg;

   localparam logic [2:0] MV_STONE    = 3'd0;
   localparam logic [2:0] MV_PAPER    = 3'd1;
   localparam logic [2:0] MV_SCISSORS = 3'd2;
   localparam logic [2:0] MV_SPOCK    = 3'd3;
   localparam logic [2:0] MV_LIZARD   = 3'd4;

`ifdef RPS_LIZARD_SPOCK_EN
   localparam int unsigned MOVES = 5;
`else
   localparam int unsigned MOVES = 3;
`endif

   localparam logic [1:0] RES_TIE = 2'b00;
   localparam logic [1:0] RES_P1  = 2'b01;
   localparam logic [1:0] RES_P2  = 2'b10;
   localparam logic [1:0] RES_INV = 2'b11;

   localparam logic [1:0] WIN_DRAW = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StPlay,
      StResolve,
      StDone
   } state_e;

endpackage

// File: rtl/rps_match_engine_if.sv
// Move handshake and per-round result bundle between a move source and the match engine.
interface rps_match_engine_if;

   logic       move_valid;
   logic [2:0] p1_move;
   logic [2:0] p2_move;
   logic       move_ready;
   logic       round_valid;
   logic [1:0] round_result;

   modport master (
      output move_valid, p1_move, p2_move,
      input  move_ready, round_valid, round_result
   );

   modport slave (
      input  move_valid, p1_move, p2_move,
      output move_ready, round_valid, round_result
   );

endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: d = (p1 - p2) mod MOVES; odd d means P1 wins, even non-zero d P2.
module rps_judge
   import rps_pkg::*;
(
   input  logic [2:0] p1_move,
   input  logic [2:0] p2_move,
   output logic [1:0] result
);

   logic [3:0] diff;

   always_comb begin
      // Both moves are below MOVES when valid, so one conditional subtract completes the modulo
      diff = {1'b0, p1_move} + 4'(MOVES) - {1'b0, p2_move};
      if (diff >= 4'(MOVES)) begin
         diff = diff - 4'(MOVES);
      end

      if (p1_move >= 3'(MOVES) || p2_move >= 3'(MOVES)) begin
         result = RES_INV;
      end else if (diff == 4'd0) begin
         result = RES_TIE;
      end else if (diff[0]) begin
         result = RES_P1;
      end else begin
         result = RES_P2;
      end
   end

endmodule

// File: rtl/rps_match_engine.sv
// First-to-WIN_TARGET stone/paper/scissors match controller with a round limit.
// Define RPS_LIZARD_SPOCK_EN to add spock (3) and lizard (4) as legal moves.
module rps_match_engine
   import rps_pkg::*;
#(
   parameter int unsigned WIN_TARGET = 3,
   parameter int unsigned MAX_ROUNDS = 15,
   parameter int unsigned SCORE_W    = 4,
   parameter int unsigned ROUND_W    = $clog2(MAX_ROUNDS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_match,
   rps_match_engine_if.slave  mv,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [ROUND_W-1:0] round_cnt,
   output logic               busy,
   output logic               match_done,
   output logic [1:0]         match_winner
);

   state_e             state_q, state_d;
   logic [2:0]         p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
   logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
   logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;
   logic               round_valid_q, round_valid_d;
   logic [1:0]         result_q, result_d;
   logic [1:0]         winner_q, winner_d;
   logic [1:0]         judge_res;

   rps_judge u_judge (
      .p1_move (p1_mv_q),
      .p2_move (p2_mv_q),
      .result  (judge_res)
   );

   always_comb begin
      state_d       = state_q;
      p1_mv_d       = p1_mv_q;
      p2_mv_d       = p2_mv_q;
      p1_score_d    = p1_score_q;
      p2_score_d    = p2_score_q;
      round_cnt_d   = round_cnt_q;
      round_valid_d = 1'b0;
      result_d      = result_q;
      winner_d      = winner_q;

      // A start request wins over everything, including an in-flight round
      if (start_match) begin
         state_d     = StPlay;
         p1_score_d  = '0;
         p2_score_d  = '0;
         round_cnt_d = '0;
         winner_d    = WIN_DRAW;
      end else begin
         unique case (state_q)
            StIdle: ;
            StPlay: begin
               if (mv.move_valid) begin
                  p1_mv_d = mv.p1_move;
                  p2_mv_d = mv.p2_move;
                  state_d = StResolve;
               end
            end
            StResolve: begin
               round_valid_d = 1'b1;
               result_d      = judge_res;
               state_d       = StPlay;
               unique case (judge_res)
                  RES_P1: begin
                     p1_score_d  = p1_score_q + SCORE_W'(1);
                     round_cnt_d = round_cnt_q + ROUND_W'(1);
                  end
                  RES_P2: begin
                     p2_score_d  = p2_score_q + SCORE_W'(1);
                     round_cnt_d = round_cnt_q + ROUND_W'(1);
                  end
                  RES_TIE: round_cnt_d = round_cnt_q + ROUND_W'(1);
                  default: ;
               endcase
               if (p1_score_d == SCORE_W'(WIN_TARGET) || p2_score_d == SCORE_W'(WIN_TARGET) ||
                   round_cnt_d == ROUND_W'(MAX_ROUNDS)) begin
                  state_d = StDone;
                  if (p1_score_d == SCORE_W'(WIN_TARGET)) begin
                     winner_d = WIN_P1;
                  end else if (p2_score_d == SCORE_W'(WIN_TARGET)) begin
                     winner_d = WIN_P2;
                  end else if (p1_score_d > p2_score_d) begin
                     winner_d = WIN_P1;
                  end else if (p2_score_d > p1_score_d) begin
                     winner_d = WIN_P2;
                  end else begin
                     winner_d = WIN_DRAW;
                  end
               end
            end
            StDone: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         p1_mv_q       <= '0;
         p2_mv_q       <= '0;
         p1_score_q    <= '0;
         p2_score_q    <= '0;
         round_cnt_q   <= '0;
         round_valid_q <= 1'b0;
         result_q      <= RES_TIE;
         winner_q      <= WIN_DRAW;
      end else begin
         state_q       <= state_d;
         p1_mv_q       <= p1_mv_d;
         p2_mv_q       <= p2_mv_d;
         p1_score_q    <= p1_score_d;
         p2_score_q    <= p2_score_d;
         round_cnt_q   <= round_cnt_d;
         round_valid_q <= round_valid_d;
         result_q      <= result_d;
         winner_q      <= winner_d;
      end
   end

   assign mv.move_ready   = (state_q == StPlay);
   assign mv.round_valid  = round_valid_q;
   assign mv.round_result = result_q;
   assign p1_score        = p1_score_q;
   assign p2_score        = p2_score_q;
   assign round_cnt       = round_cnt_q;
   assign busy            = (state_q == StPlay) || (state_q == StResolve);
   assign match_done      = (state_q == StDone);
   assign match_winner    = winner_q;

endmodule

// File: tb/tb_rps_match_engine.sv
// Randomized self-checking bench for rps_match_engine against a rule-level match model.
module tb_rps_match_engine;

   localparam int unsigned WT = 3;
   localparam int unsigned MR = 4;
   localparam int unsigned SW = 4;
   localparam int unsigned RW = $clog2(MR + 1);
`ifdef RPS_LIZARD_SPOCK_EN
   localparam int M = 5;
`else
   localparam int M = 3;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start_match;
   logic [SW-1:0] p1_score, p2_score;
   logic [RW-1:0] round_cnt;
   logic          busy, match_done;
   logic [1:0]    match_winner;

   int checks = 0;
   int errors = 0;

   // Reference match state
   int m_p1, m_p2, m_rc, m_win;
   bit m_done;

   rps_match_engine_if bus ();

   rps_match_engine #(
      .WIN_TARGET (WT),
      .MAX_ROUNDS (MR),
      .SCORE_W    (SW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_match  (start_match),
      .mv           (bus),
      .p1_score     (p1_score),
      .p2_score     (p2_score),
      .round_cnt    (round_cnt),
      .busy         (busy),
      .match_done   (match_done),
      .match_winner (match_winner)
   );

   always #5 clk = ~clk;

   function automatic int ref_judge(int a, int b);
      int d;
      if (a >= M || b >= M) return 3;
      d = ((a - b) % M + M) % M;
      if (d == 0) return 0;
      if (M == 3) return (d == 1) ? 1 : 2;
      return (d == 1 || d == 3) ? 1 : 2;
   endfunction

   task automatic model_clear();
      m_p1 = 0; m_p2 = 0; m_rc = 0; m_win = 0; m_done = 0;
   endtask

   task automatic model_apply(input int res);
      if (res == 1) begin m_p1++; m_rc++; end
      if (res == 2) begin m_p2++; m_rc++; end
      if (res == 0) m_rc++;
      if (m_p1 == WT || m_p2 == WT || m_rc == MR) begin
         m_done = 1;
         if (m_p1 == WT) m_win = 1;
         else if (m_p2 == WT) m_win = 2;
         else if (m_p1 > m_p2) m_win = 1;
         else if (m_p2 > m_p1) m_win = 2;
         else m_win = 0;
      end
   endtask

   task automatic do_start();
      start_match = 1'b1;
      @(posedge clk); #1;
      start_match = 1'b0;
      model_clear();
   endtask

   // Drives one round and returns what was observed after the accept edge and the result edge
   task automatic play_round(input logic [2:0] a, input logic [2:0] b, output bit to,
                             output logic rdy0, output logic rv0, output logic rv1,
                             output logic [1:0] res);
      int n;
      n  = 0;
      to = 0;
      while (bus.move_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.move_ready !== 1'b1) to = 1;
      bus.move_valid = 1'b1;
      bus.p1_move    = a;
      bus.p2_move    = b;
      @(posedge clk); #1;
      bus.move_valid = 1'b0;
      bus.p1_move    = 3'($urandom);
      bus.p2_move    = 3'($urandom);
      rdy0 = bus.move_ready;
      rv0  = bus.round_valid;
      @(posedge clk); #1;
      rv1 = bus.round_valid;
      res = bus.round_result;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_match = 1'b0;
      bus.move_valid = 1'b0; bus.p1_move = '0; bus.p2_move = '0;
      #1;
      checks++;
      if ({bus.move_ready, bus.round_valid, bus.round_result, p1_score, p2_score, round_cnt,
           busy, match_done, match_winner} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b rv=%b res=%b s1=%0d s2=%0d rc=%0d busy=%b done=%b win=%b, want all 0",
                  bus.move_ready, bus.round_valid, bus.round_result, p1_score, p2_score, round_cnt,
                  busy, match_done, match_winner);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus.move_valid = 1'b1;
      @(posedge clk); #1;
      bus.move_valid = 1'b0;
      checks++;
      if (bus.move_ready !== 1'b0 || bus.round_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores_moves: rdy=%b rv=%b busy=%b, want 0 0 0",
                  bus.move_ready, bus.round_valid, busy);
      end
   endtask

   task automatic test_p1_match();
      logic [2:0] ta[3] = '{3'd0, 3'd1, 3'd2};
      logic [2:0] tb[3] = '{3'd2, 3'd0, 3'd1};
      bit to; logic rdy0, rv0, rv1; logic [1:0] res;
      do_start();
      checks++;
      if (busy !== 1'b1 || bus.move_ready !== 1'b1 || match_done !== 1'b0 || round_cnt !== '0) begin
         errors++;
         $display("FAIL start_state: busy=%b rdy=%b done=%b rc=%0d, want 1 1 0 0",
                  busy, bus.move_ready, match_done, round_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         play_round(ta[i], tb[i], to, rdy0, rv0, rv1, res);
         model_apply(1);
         checks++;
         if (to || rdy0 !== 1'b0 || rv0 !== 1'b0 || rv1 !== 1'b1 || res !== 2'b01) begin
            errors++;
            $display("FAIL p1_round%0d: to=%0d rdy0=%b rv0=%b rv1=%b res=%b, want 0 0 0 1 01",
                     i, to, rdy0, rv0, rv1, res);
         end
      end
      checks++;
      if (p1_score !== SW'(3) || p2_score !== '0 || round_cnt !== RW'(3) || match_done !== 1'b1 ||
          match_winner !== 2'b01 || busy !== 1'b0 || bus.move_ready !== 1'b0) begin
         errors++;
         $display("FAIL p1_match_end: s1=%0d s2=%0d rc=%0d done=%b win=%b busy=%b rdy=%b, want 3 0 3 1 01 0 0",
                  p1_score, p2_score, round_cnt, match_done, match_winner, busy, bus.move_ready);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (match_done !== 1'b1 || match_winner !== 2'b01 || bus.round_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_hold: done=%b win=%b rv=%b, want 1 01 0",
                  match_done, match_winner, bus.round_valid);
      end
   endtask

   // Shared by tie/invalid, round-limit and lizard scenarios: plays a list and checks each round
   task automatic test_table(input string name, input int n, input logic [2:0] ta[6],
                             input logic [2:0] tb[6]);
      bit to; logic rdy0, rv0, rv1; logic [1:0] res; int exp;
      do_start();
      for (int i = 0; i < n; i++) begin
         play_round(ta[i], tb[i], to, rdy0, rv0, rv1, res);
         exp = ref_judge(int'(ta[i]), int'(tb[i]));
         model_apply(exp);
         checks++;
         if (to || rv1 !== 1'b1 || res !== 2'(exp) || rdy0 !== 1'b0 || rv0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_r%0d_result: to=%0d rv=%b res=%b, want rv=1 res=%b",
                     name, i, to, rv1, res, 2'(exp));
         end
         checks++;
         if (p1_score !== SW'(m_p1) || p2_score !== SW'(m_p2) || round_cnt !== RW'(m_rc) ||
             match_done !== m_done || match_winner !== 2'(m_win)) begin
            errors++;
            $display("FAIL %s_r%0d_state: s1=%0d s2=%0d rc=%0d done=%b win=%b, want %0d %0d %0d %0d %0d",
                     name, i, p1_score, p2_score, round_cnt, match_done, match_winner,
                     m_p1, m_p2, m_rc, m_done, m_win);
         end
      end
   endtask

   task automatic test_tie_invalid();
      test_table("tie_inv", 3, '{3'd2, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0},
                 '{3'd2, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0});
   endtask

   task automatic test_round_limit();
      test_table("limit_draw", 4, '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0},
                 '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd0});
      checks++;
      if (match_done !== 1'b1 || match_winner !== 2'b00 || round_cnt !== RW'(4)) begin
         errors++;
         $display("FAIL limit_draw_end: done=%b win=%b rc=%0d, want 1 00 4",
                  match_done, match_winner, round_cnt);
      end
      test_table("limit_p1", 4, '{3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0},
                 '{3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0});
      checks++;
      if (match_done !== 1'b1 || match_winner !== 2'b01 || p1_score !== SW'(2)) begin
         errors++;
         $display("FAIL limit_p1_end: done=%b win=%b s1=%0d, want 1 01 2",
                  match_done, match_winner, p1_score);
      end
   endtask

   task automatic test_back_to_back();
      bit exp_rdy; int exp_res; logic [2:0] a, b;
      exp_res = 0;
      do_start();
      bus.move_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_rdy = (i % 2 == 0);
         checks++;
         if (bus.move_ready !== exp_rdy) begin
            errors++;
            $display("FAIL b2b_ready%0d: rdy=%b, want %b", i, bus.move_ready, exp_rdy);
         end
         a = 3'($urandom_range(0, M - 1));
         b = 3'($urandom_range(0, M - 1));
         bus.p1_move = a;
         bus.p2_move = b;
         if (exp_rdy) begin
            exp_res = ref_judge(int'(a), int'(b));
            model_apply(exp_res);
         end
         @(posedge clk); #1;
         checks++;
         if (bus.round_valid !== !exp_rdy || (!exp_rdy && bus.round_result !== 2'(exp_res))) begin
            errors++;
            $display("FAIL b2b_pulse%0d: rv=%b res=%b, want rv=%b res=%b", i, bus.round_valid,
                     bus.round_result, !exp_rdy, 2'(exp_res));
         end
      end
      bus.move_valid = 1'b0;
      checks++;
      if (round_cnt !== RW'(m_rc) || p1_score !== SW'(m_p1) || p2_score !== SW'(m_p2)) begin
         errors++;
         $display("FAIL b2b_counts: rc=%0d s1=%0d s2=%0d, want %0d %0d %0d",
                  round_cnt, p1_score, p2_score, m_rc, m_p1, m_p2);
      end
   endtask

   task automatic test_abort();
      bit to; logic rdy0, rv0, rv1; logic [1:0] res;
      do_start();
      play_round(3'd1, 3'd0, to, rdy0, rv0, rv1, res);
      // Start and moves together while in PLAY
      bus.move_valid = 1'b1; bus.p1_move = 3'd1; bus.p2_move = 3'd0; start_match = 1'b1;
      @(posedge clk); #1;
      bus.move_valid = 1'b0; start_match = 1'b0;
      checks++;
      if (p1_score !== '0 || round_cnt !== '0 || bus.move_ready !== 1'b1 || busy !== 1'b1 ||
          bus.round_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_play: s1=%0d rc=%0d rdy=%b busy=%b rv=%b, want 0 0 1 1 0",
                  p1_score, round_cnt, bus.move_ready, busy, bus.round_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.round_valid !== 1'b0 || p1_score !== '0) begin
         errors++;
         $display("FAIL abort_play_nopulse: rv=%b s1=%0d, want 0 0", bus.round_valid, p1_score);
      end
      // Start while the accepted round is resolving
      bus.move_valid = 1'b1; bus.p1_move = 3'd2; bus.p2_move = 3'd1;
      @(posedge clk); #1;
      bus.move_valid = 1'b0; start_match = 1'b1;
      @(posedge clk); #1;
      start_match = 1'b0;
      checks++;
      if (bus.round_valid !== 1'b0 || p1_score !== '0 || round_cnt !== '0 ||
          bus.move_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_resolve: rv=%b s1=%0d rc=%0d rdy=%b, want 0 0 0 1",
                  bus.round_valid, p1_score, round_cnt, bus.move_ready);
      end
      model_clear();
   endtask

   task automatic test_rst_resolve();
      bit to; logic rdy0, rv0, rv1; logic [1:0] res;
      do_start();
      play_round(3'd1, 3'd0, to, rdy0, rv0, rv1, res);
      bus.move_valid = 1'b1; bus.p1_move = 3'd0; bus.p2_move = 3'd2;
      @(posedge clk); #1;
      bus.move_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.move_ready, bus.round_valid, bus.round_result, p1_score, p2_score, round_cnt,
           busy, match_done, match_winner} !== '0) begin
         errors++;
         $display("FAIL rst_resolve: rdy=%b rv=%b res=%b s1=%0d rc=%0d busy=%b done=%b, want all 0",
                  bus.move_ready, bus.round_valid, bus.round_result, p1_score, round_cnt, busy,
                  match_done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.round_valid !== 1'b0 || busy !== 1'b0 || p1_score !== '0) begin
         errors++;
         $display("FAIL rst_no_pulse: rv=%b busy=%b s1=%0d, want 0 0 0",
                  bus.round_valid, busy, p1_score);
      end
   endtask

   task automatic test_random();
      bit to; logic rdy0, rv0, rv1; logic [1:0] res; int exp, n;
      logic [2:0] a, b;
      for (int k = 0; k < 30; k++) begin
         do_start();
         n = 0;
         while (!m_done && n < 40) begin
            a = 3'($urandom_range(0, 5));
            b = 3'($urandom_range(0, 5));
            play_round(a, b, to, rdy0, rv0, rv1, res);
            exp = ref_judge(int'(a), int'(b));
            model_apply(exp);
            checks++;
            if (to || rv1 !== 1'b1 || res !== 2'(exp) || p1_score !== SW'(m_p1) ||
                p2_score !== SW'(m_p2) || round_cnt !== RW'(m_rc) || match_done !== m_done ||
                match_winner !== 2'(m_win)) begin
               errors++;
               $display("FAIL rand_m%0d_r%0d (%0d,%0d): rv=%b res=%b s=%0d/%0d rc=%0d done=%b win=%b, want res=%0d s=%0d/%0d rc=%0d done=%0d win=%0d",
                        k, n, a, b, rv1, res, p1_score, p2_score, round_cnt, match_done,
                        match_winner, exp, m_p1, m_p2, m_rc, m_done, m_win);
            end
            n++;
         end
      end
   endtask

`ifdef RPS_LIZARD_SPOCK_EN
   task automatic test_lizard();
      test_table("lizard", 3, '{3'd4, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0},
                 '{3'd3, 3'd4, 3'd1, 3'd0, 3'd0, 3'd0});
      checks++;
      if (p1_score !== SW'(2) || p2_score !== SW'(1) || bus.round_result !== 2'b10) begin
         errors++;
         $display("FAIL lizard_end: s1=%0d s2=%0d res=%b, want 2 1 10",
                  p1_score, p2_score, bus.round_result);
      end
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      model_clear();
      test_reset();
      test_p1_match();
      test_tie_invalid();
      test_round_limit();
      test_back_to_back();
      test_abort();
      test_rst_resolve();
`ifdef RPS_LIZARD_SPOCK_EN
      test_lizard();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
